// File: rtl/ql_config_frame_loader_if.sv
// Configuration word stream between a bitstream source and the frame loader.
interface ql_config_frame_loader_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/ql_config_frame_loader.sv
// Assembles one BL row per WL row from a word stream, strobes the row's word
// line for PROG_CYCLES cycles, walks every row and then flags completion.
module ql_config_frame_loader #(
  parameter int BL_WIDTH    = 514,
  parameter int WL_WIDTH    = 407,
  parameter int DATA_W      = 32,
  parameter int PROG_CYCLES = 4
) (
  input  logic                      clk,
  input  logic                      global_resetn,
  input  logic                      start,
  ql_config_frame_loader_if.slave   cfg_if,
  output logic [0:BL_WIDTH-1]       bl,
  output logic [0:WL_WIDTH-1]       wl,
  output logic                      busy,
  output logic                      cfg_done
);

  localparam int WORDS = (BL_WIDTH + DATA_W - 1) / DATA_W;
  localparam int WCW   = (WORDS > 1)       ? $clog2(WORDS)       : 1;
  localparam int RW    = (WL_WIDTH > 1)    ? $clog2(WL_WIDTH)    : 1;
  localparam int PW    = (PROG_CYCLES > 1) ? $clog2(PROG_CYCLES) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_PROG = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]          state_q, state_d;
  logic [RW-1:0]       row_q, row_d;
  logic [WCW-1:0]      word_q, word_d;
  logic [PW-1:0]       pcnt_q, pcnt_d;
  logic [0:BL_WIDTH-1] shadow_q, shadow_d;
  logic [0:BL_WIDTH-1] wr_mask, wr_val;
  logic [0:WL_WIDTH-1] row_sel;
  logic                run_q;

  logic [0:BL_WIDTH-1] bl_q;
  logic [0:WL_WIDTH-1] wl_q;
  logic                in_ready_q, busy_q, cfg_done_q;

  // Shadow bit i belongs to word i/DATA_W, bit i%DATA_W; the tail of the
  // last word has no shadow bit and is dropped.
  for (genvar i = 0; i < BL_WIDTH; i++) begin : g_wr
    assign wr_mask[i] = (word_q == WCW'(i / DATA_W));
    assign wr_val[i]  = cfg_if.in_data[i % DATA_W];
  end

  for (genvar i = 0; i < WL_WIDTH; i++) begin : g_wl
    assign row_sel[i] = (row_d == RW'(i));
  end

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    word_d   = word_q;
    pcnt_d   = pcnt_q;
    shadow_d = shadow_q;
    // run_q holds the FSM still on the first edge after reset release.
    if (run_q) begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_d  = S_LOAD;
            row_d    = '0;
            word_d   = '0;
            shadow_d = '0;
          end
        end
        S_LOAD: begin
          if (cfg_if.in_valid && in_ready_q) begin
            shadow_d = (shadow_q & ~wr_mask) | (wr_val & wr_mask);
            if (word_q == WCW'(WORDS - 1)) begin
              word_d  = '0;
              pcnt_d  = '0;
              state_d = S_PROG;
            end else begin
              word_d = word_q + WCW'(1);
            end
          end
        end
        S_PROG: begin
          if (pcnt_q == PW'(PROG_CYCLES - 1)) begin
            pcnt_d = '0;
            if (row_q == RW'(WL_WIDTH - 1)) begin
              row_d   = '0;
              state_d = S_DONE;
            end else begin
              row_d    = row_q + RW'(1);
              word_d   = '0;
              shadow_d = '0;
              state_d  = S_LOAD;
            end
          end else begin
            pcnt_d = pcnt_q + PW'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge global_resetn) begin
    if (!global_resetn) begin
      run_q    <= 1'b0;
      state_q  <= S_IDLE;
      row_q    <= '0;
      word_q   <= '0;
      pcnt_q   <= '0;
      shadow_q <= '0;
    end else begin
      run_q    <= 1'b1;
      state_q  <= state_d;
      row_q    <= row_d;
      word_q   <= word_d;
      pcnt_q   <= pcnt_d;
      shadow_q <= shadow_d;
    end
  end

  // Outputs are registered from next-state so they line up with the state
  // they describe; BL/WL are isolated (zero) outside PROG.
  always_ff @(posedge clk or negedge global_resetn) begin
    if (!global_resetn) begin
      bl_q       <= '0;
      wl_q       <= '0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      cfg_done_q <= 1'b0;
    end else begin
      bl_q       <= (state_d == S_PROG) ? shadow_d : '0;
      wl_q       <= (state_d == S_PROG) ? row_sel  : '0;
      in_ready_q <= (state_d == S_LOAD);
      busy_q     <= (state_d == S_LOAD) || (state_d == S_PROG);
      cfg_done_q <= (state_d == S_DONE);
    end
  end

  assign bl              = bl_q;
  assign wl              = wl_q;
  assign busy            = busy_q;
  assign cfg_done        = cfg_done_q;
  assign cfg_if.in_ready = in_ready_q;

endmodule
